dff_bank_arbiter: RTL and testbench
===================================

Name: dff_bank_arbiter

Overview:
Round-robin arbiter and sequencer that shares one WIDTH-bit D flip-flop register bank among N_REQ requesters. Each granted request is turned into exactly one cycle of bank control: a clear, set, load or read. The clear/set/load precedence matches the flip-flop's own control priority. The block sits between client logic and the shared flip-flop bank, which uses a synchronous clear/set and a write enable.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, register bank width in bits
MAX_LOCK, 4, max consecutive grants to one locked requester (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  N_REQ  per-requester request; held until matching ack bit
lock  input  N_REQ  per-requester request to retain ownership for back-to-back ops
op  input  2*N_REQ  per-requester opcode, bits [2i+1:2i]: 00 LOAD, 01 SET, 10 CLR, 11 READ
wdata  input  WIDTH*N_REQ  per-requester load data, bits [WIDTH*i +: WIDTH]
ff_q  input  WIDTH  current flip-flop bank contents
ff_we  output  1  bank write enable
ff_clr  output  1  bank synchronous clear, highest priority
ff_set  output  1  bank synchronous set-all-ones
ff_d  output  WIDTH  bank load data
gnt  output  N_REQ  one-hot grant, valid in ISSUE
ack  output  N_REQ  one-cycle completion pulse to the granted requester
rdata  output  WIDTH  ff_q sampled for READ, valid with ack
busy  output  1  high while in ISSUE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: every output is 0. State goes to IDLE, last-grant pointer goes to N_REQ-1 (requester 0 is first), lock_cnt goes to 0. A reset asserted during ISSUE aborts the op: no ack, and ff_we/ff_clr/ff_set read 0 from the next cycle.
- FSM states: IDLE and ISSUE. Every op costs exactly 2 cycles: arbitrate, then issue. Peak throughput is 1 op per 2 cycles.
- IDLE:
  - With no req, stay in IDLE. All outputs are 0.
  - With any req bit set, pick the winner g:
    - Lock rule first: if the previous owner p has lock[p]=1, req[p]=1 and lock_cnt<MAX_LOCK-1, then g=p and lock_cnt increments.
    - Otherwise round-robin: g is the first set req bit searching from pointer+1 upward with wrap. lock_cnt clears to 0.
  - Register g, op[g] and wdata[g]. Go to ISSUE.
- ISSUE (one cycle): all outputs are registered, driven from the captured values.
  - gnt = one-hot g, busy = 1, ack[g] = 1.
  - LOAD: ff_we=1, ff_d=wdata.
  - SET: ff_we=1, ff_set=1, ff_d=0.
  - CLR: ff_we=1, ff_clr=1, ff_d=0.
  - READ: ff_we=0, and rdata = ff_q sampled at the IDLE->ISSUE edge.
  - Exactly one of ff_clr, ff_set or a plain load is active per write.
  - Next state is always IDLE. The pointer updates to g. rdata holds its value until the next READ.
- Handshake:
  - A requester must hold req, op, wdata and lock stable until it sees its ack bit.
  - Dropping req before ack is illegal, but the block must tolerate it: the captured op still completes.
  - Deasserting req in the ack cycle means no re-request.
- Simultaneous events:
  - A new req arriving during ISSUE is arbitrated in the following IDLE cycle.
  - All requesters asserting at once are served in rotation 0,1,2,3,0...
- Lock bound: a single requester never receives more than MAX_LOCK consecutive grants while any other req is pending. If no other requester is pending, round-robin re-selects the same requester anyway.
- Width rule: ff_d is exactly WIDTH bits. Opcodes are fully decoded, so no illegal opcode exists.

Test Plan:
1. Reset, then hold req=0 for 5 cycles -> all outputs 0, busy 0. Assert rst during ISSUE of a LOAD -> no ack, ff_we=0 next cycle.
2. req[1]=1, op=LOAD, wdata=0xA5 -> ISSUE one cycle later with gnt=0010, ff_we=1, ff_d=0xA5, ack=0010. Next cycle is IDLE.
3. Requester 0 sends CLR, then SET, then READ with ff_q=0xFF -> pulses are ff_we+ff_clr, then ff_we+ff_set, then ack with rdata=0xFF and ff_we=0.
4. req=1111 held, refreshed after each ack -> grants 0,1,2,3,0,1, each spaced 2 cycles, and no gnt is ever multi-hot.
5. With MAX_LOCK=4, lock[2]=1 and req=0101 continuously -> first grant goes to requester 0. With lock[2] held and requester 2 re-requesting, requester 2 gets 4 consecutive grants, then requester 0 is granted.
6. req[3] drops one cycle after capture (illegal) -> the op still issues with ack[3]=1 and the FSM returns to IDLE.

Source files
------------

// File: rtl/dff_bank_arbiter_if.sv
// Client/bank-side bundle for dff_bank_arbiter: per-requester request fields
// plus the shared flip-flop bank control and completion signals.
interface dff_bank_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [2*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] wdata;
  logic [WIDTH-1:0]       ff_q;
  logic                   ff_we;
  logic                   ff_clr;
  logic                   ff_set;
  logic [WIDTH-1:0]       ff_d;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       rdata;
  logic                   busy;

  modport master (
    output req, lock, op, wdata, ff_q,
    input  ff_we, ff_clr, ff_set, ff_d, gnt, ack, rdata, busy
  );

  modport slave (
    input  req, lock, op, wdata, ff_q,
    output ff_we, ff_clr, ff_set, ff_d, gnt, ack, rdata, busy
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter with bounded lock that turns each grant into a single
// cycle of clear/set/load/read control on a shared flip-flop bank.
module dff_bank_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic            clk,
  input  logic            rst,
  dff_bank_arbiter_if.slave bus
);
  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNTW = $clog2(MAX_LOCK + 1);
  localparam logic [CNTW-1:0] LOCK_LIMIT = CNTW'(MAX_LOCK - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  logic [0:0]       state_reg;
  logic [IDXW-1:0]  ptr_reg;
  logic [CNTW-1:0]  lock_cnt_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic [N_REQ-1:0] ack_reg;
  logic             ff_we_reg;
  logic             ff_clr_reg;
  logic             ff_set_reg;
  logic [WIDTH-1:0] ff_d_reg;
  logic [WIDTH-1:0] rdata_reg;
  logic             busy_reg;

  logic [1:0]       op_arr    [N_REQ];
  logic [WIDTH-1:0] wdata_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_arr[gi]    = bus.op[2*gi +: 2];
      assign wdata_arr[gi] = bus.wdata[WIDTH*gi +: WIDTH];
    end
  endgenerate

  logic [IDXW-1:0] win_next;
  logic [IDXW-1:0] cand;
  logic            found;
  logic            lock_hit;

  // The previous owner keeps the bank while it holds lock, unless its streak
  // has reached MAX_LOCK; otherwise search upward from the last grant.
  always_comb begin
    win_next = ptr_reg;
    cand     = '0;
    found    = 1'b0;
    lock_hit = bus.lock[ptr_reg] && bus.req[ptr_reg] && (lock_cnt_reg < LOCK_LIMIT);
    if (!lock_hit) begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = IDXW'((int'(ptr_reg) + k) % N_REQ);
        if (!found && bus.req[cand]) begin
          win_next = cand;
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= IDXW'(N_REQ - 1);
      lock_cnt_reg <= '0;
      gnt_reg      <= '0;
      ack_reg      <= '0;
      ff_we_reg    <= 1'b0;
      ff_clr_reg   <= 1'b0;
      ff_set_reg   <= 1'b0;
      ff_d_reg     <= '0;
      rdata_reg    <= '0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            state_reg    <= ISSUE;
            ptr_reg      <= win_next;
            lock_cnt_reg <= lock_hit ? lock_cnt_reg + CNTW'(1) : '0;
            gnt_reg      <= ONE_HOT0 << win_next;
            ack_reg      <= ONE_HOT0 << win_next;
            busy_reg     <= 1'b1;
            ff_we_reg    <= 1'b0;
            ff_clr_reg   <= 1'b0;
            ff_set_reg   <= 1'b0;
            ff_d_reg     <= '0;
            case (op_arr[win_next])
              OP_LOAD: begin
                ff_we_reg <= 1'b1;
                ff_d_reg  <= wdata_arr[win_next];
              end
              OP_SET: begin
                ff_we_reg  <= 1'b1;
                ff_set_reg <= 1'b1;
              end
              OP_CLR: begin
                ff_we_reg  <= 1'b1;
                ff_clr_reg <= 1'b1;
              end
              OP_READ: rdata_reg <= bus.ff_q;
              default: ;
            endcase
          end
        end
        ISSUE: begin
          // rdata deliberately keeps its value until the next READ.
          state_reg  <= IDLE;
          gnt_reg    <= '0;
          ack_reg    <= '0;
          busy_reg   <= 1'b0;
          ff_we_reg  <= 1'b0;
          ff_clr_reg <= 1'b0;
          ff_set_reg <= 1'b0;
          ff_d_reg   <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A reset arriving mid-ISSUE suppresses the completion pulse immediately.
  assign bus.ack    = ack_reg & ~{N_REQ{rst}};
  assign bus.gnt    = gnt_reg;
  assign bus.busy   = busy_reg;
  assign bus.ff_we  = ff_we_reg;
  assign bus.ff_clr = ff_clr_reg;
  assign bus.ff_set = ff_set_reg;
  assign bus.ff_d   = ff_d_reg;
  assign bus.rdata  = rdata_reg;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed scenarios plus randomized traffic
// checked against a grant-streak model and a behavioural flip-flop bank.
module tb_dff_bank_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ML = 4;
  localparam int VW = 2*N + 4 + W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dff_bank_arbiter_if #(.N_REQ(N), .WIDTH(W)) bif ();
  dff_bank_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_LOCK(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Behavioural shared bank: clear beats set beats load.
  logic [W-1:0] bank = '0;
  always @(posedge clk)
    if (bif.ff_we) bank <= bif.ff_clr ? '0 : (bif.ff_set ? '1 : bif.ff_d);
  assign bif.ff_q = bank;

  int checks = 0;
  int fails  = 0;

  // Model: last owner and how many consecutive grants it has received.
  int           m_ptr;
  int           m_streak;
  logic [W-1:0] m_bank;

  function automatic bit bitat(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  task automatic model_reset();
    m_ptr    = N - 1;
    m_streak = 1;
  endtask

  task automatic model_grant(input logic [N-1:0] r, input logic [N-1:0] l, output int g);
    g = -1;
    if (bitat(l, m_ptr) && bitat(r, m_ptr) && m_streak < ML) begin
      g = m_ptr;
      m_streak++;
    end else begin
      for (int k = 1; k <= N; k++)
        if (g < 0 && bitat(r, (m_ptr + k) % N)) g = (m_ptr + k) % N;
      m_streak = 1;
    end
    m_ptr = g;
  endtask

  function automatic logic [W-1:0] apply_op(input logic [W-1:0] b, input logic [1:0] o,
                                            input logic [W-1:0] d);
    case (o)
      2'b00:   return d;
      2'b01:   return '1;
      2'b10:   return '0;
      default: return b;
    endcase
  endfunction

  function automatic logic [VW-1:0] expv(input int g, input logic [1:0] o, input logic [W-1:0] d);
    logic [N-1:0] oh;
    oh = N'(1) << g;
    return {oh, oh, 1'b1, (o != 2'b11), (o == 2'b10), (o == 2'b01),
            (o == 2'b00) ? d : {W{1'b0}}};
  endfunction

  function automatic logic [VW-1:0] obs();
    return {bif.gnt, bif.ack, bif.busy, bif.ff_we, bif.ff_clr, bif.ff_set, bif.ff_d};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [2*N-1:0] o, input logic [W*N-1:0] wd);
    bif.req   = r;
    bif.lock  = l;
    bif.op    = o;
    bif.wdata = wd;
  endtask

  task automatic wait_issue(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bif.busy === 1'b1) begin
        ok  = 1'b1;
        cyc = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bit ok;
    int cyc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs() !== '0 || bif.rdata !== '0) begin
        fails++;
        $display("FAIL reset_idle[%0d]: outputs %h rdata %h, required all 0", i, obs(), bif.rdata);
      end
    end
    drive(4'b0001, '0, '0, {24'h0, 8'h3C});
    wait_issue(ok, cyc);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL reset_abort_issue: no ISSUE seen, busy %b required 1", bif.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bif.ack !== '0) begin
      fails++;
      $display("FAIL reset_abort_ack: ack %b required 0000", bif.ack);
    end
    drive('0, '0, '0, '0);
    tick();
    checks++;
    if (obs() !== '0) begin
      fails++;
      $display("FAIL reset_abort_after: outputs %h required 0", obs());
    end
    rst = 1'b0;
    model_reset();
    m_bank = 8'h3C;
  endtask

  task automatic test_load();
    bit ok;
    int cyc, g;
    drive(4'b0010, '0, '0, {16'h0, 8'hA5, 8'h0});
    wait_issue(ok, cyc);
    model_grant(4'b0010, '0, g);
    checks++;
    if (!ok || obs() !== expv(g, 2'b00, 8'hA5) || g != 1) begin
      fails++;
      $display("FAIL load_issue: got %h required %h (model g=%0d)", obs(), expv(1, 2'b00, 8'hA5), g);
    end
    m_bank = 8'hA5;
    drive('0, '0, '0, '0);
    tick();
    checks++;
    if (obs() !== '0) begin
      fails++;
      $display("FAIL load_back_to_idle: outputs %h required 0", obs());
    end
  endtask

  task automatic test_clr_set_read();
    logic [1:0] seq [3];
    bit ok;
    int cyc, g;
    seq[0] = 2'b10; seq[1] = 2'b01; seq[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, '0, {6'b0, seq[i]}, {24'h0, 8'h5A});
      wait_issue(ok, cyc);
      model_grant(4'b0001, '0, g);
      checks++;
      if (!ok || obs() !== expv(g, seq[i], 8'h5A)) begin
        fails++;
        $display("FAIL csr_op[%0d]: got %h required %h", i, obs(), expv(g, seq[i], 8'h5A));
      end
      if (seq[i] == 2'b11) begin
        checks++;
        if (bif.rdata !== m_bank || m_bank !== 8'hFF) begin
          fails++;
          $display("FAIL csr_rdata: got %h required %h", bif.rdata, 8'hFF);
        end
      end
      m_bank = apply_op(m_bank, seq[i], 8'h5A);
      drive('0, '0, '0, '0);
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [2*N-1:0] ops;
    logic [W*N-1:0] wds;
    logic [1:0]     og;
    logic [W-1:0]   dg;
    bit ok;
    int cyc, g;
    do_reset();
    ops = 8'($urandom);
    wds = 32'($urandom);
    drive(4'b1111, '0, ops, wds);
    for (int k = 0; k < 6; k++) begin
      wait_issue(ok, cyc);
      model_grant(4'b1111, '0, g);
      og = 2'(ops >> (2*g));
      dg = W'(wds >> (W*g));
      checks++;
      if (!ok || obs() !== expv(g, og, dg) || g != k % N || !$onehot(bif.gnt)) begin
        fails++;
        $display("FAIL rr_grant[%0d]: got %h required %h", k, obs(), expv(k % N, og, dg));
      end
      if (k > 0) begin
        checks++;
        if (cyc != 2) begin
          fails++;
          $display("FAIL rr_spacing[%0d]: %0d cycles required 2", k, cyc);
        end
      end
      if (og == 2'b11) begin
        checks++;
        if (bif.rdata !== m_bank) begin
          fails++;
          $display("FAIL rr_rdata[%0d]: got %h required %h", k, bif.rdata, m_bank);
        end
      end
      m_bank = apply_op(m_bank, og, dg);
    end
    drive('0, '0, '0, '0);
    tick();
  endtask

  task automatic test_lock();
    int want [6];
    bit ok;
    int cyc, g;
    want = '{0, 2, 2, 2, 2, 0};
    do_reset();
    drive(4'b0101, 4'b0100, '0, {8'h22, 8'h11, 8'h44, 8'h33});
    for (int k = 0; k < 6; k++) begin
      wait_issue(ok, cyc);
      model_grant(4'b0101, 4'b0100, g);
      checks++;
      if (!ok || g != want[k] || obs() !== expv(want[k], 2'b00, (want[k] == 2) ? 8'h11 : 8'h33)) begin
        fails++;
        $display("FAIL lock_grant[%0d]: gnt %b required requester %0d", k, bif.gnt, want[k]);
      end
      m_bank = (want[k] == 2) ? 8'h11 : 8'h33;
    end
    drive('0, '0, '0, '0);
    tick();
  endtask

  task automatic test_drop_req();
    int g;
    drive(4'b1000, '0, 8'b00_000000, {8'hC3, 24'h0});
    @(posedge clk);
    #1;
    drive('0, '0, '0, '0);
    model_grant(4'b1000, '0, g);
    tick();
    checks++;
    if (obs() !== expv(3, 2'b00, 8'hC3)) begin
      fails++;
      $display("FAIL drop_req_issue: got %h required %h", obs(), expv(3, 2'b00, 8'hC3));
    end
    m_bank = 8'hC3;
    tick();
    checks++;
    if (obs() !== '0) begin
      fails++;
      $display("FAIL drop_req_idle: outputs %h required 0", obs());
    end
  endtask

  task automatic test_random();
    logic [N-1:0]   r, l;
    logic [2*N-1:0] o;
    logic [W*N-1:0] wd;
    logic [1:0]     og;
    logic [W-1:0]   dg;
    bit ok;
    int cyc, g, x;
    r  = N'($urandom_range(1, 15));
    l  = N'($urandom);
    o  = 8'($urandom);
    wd = 32'($urandom);
    drive(r, l, o, wd);
    for (int t = 0; t < 40; t++) begin
      wait_issue(ok, cyc);
      model_grant(r, l, g);
      og = 2'(o >> (2*g));
      dg = W'(wd >> (W*g));
      checks++;
      if (!ok || obs() !== expv(g, og, dg)) begin
        fails++;
        $display("FAIL rand_op[%0d]: got %h required %h (req %b lock %b)", t, obs(), expv(g, og, dg), r, l);
      end
      if (og == 2'b11) begin
        checks++;
        if (bif.rdata !== m_bank) begin
          fails++;
          $display("FAIL rand_rdata[%0d]: got %h required %h", t, bif.rdata, m_bank);
        end
      end
      m_bank = apply_op(m_bank, og, dg);
      // Ack cycle: the winner may drop or re-request; idle requesters may join.
      for (int i = 0; i < N; i++) begin
        if (i == g || !bitat(r, i)) begin
          r[i]          = ($urandom_range(0, 2) != 0);
          l[i]          = $urandom_range(0, 1) != 0;
          o[2*i +: 2]   = 2'($urandom);
          wd[W*i +: W]  = W'($urandom);
        end
      end
      if (r == '0) begin
        x    = $urandom_range(0, N - 1);
        r[x] = 1'b1;
      end
      drive(r, l, o, wd);
    end
    drive('0, '0, '0, '0);
    tick();
  endtask

  initial begin
    drive('0, '0, '0, '0);
    m_bank = '0;
    model_reset();
    test_reset();
    test_load();
    test_clr_set_read();
    test_round_robin();
    test_lock();
    test_drop_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
